// File: rtl/aes128_cipher_core_pkg.sv
// Shared AES definitions for the iterative cipher core.
//   NR      : round count for AES-128
//   state_t : core FSM encoding (IDLE/RUN/DONE)
//   sbox    : forward S-box lookup
//   xtime   : multiply by 2 in GF(2^8)
//   gf_mul3 : multiply by 3 in GF(2^8)
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = '0;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aes128_cipher_core_if.sv
// Block-in / block-out handshake bundle of the AES-128 cipher core.
//   in_valid/in_ready   : plaintext + key schedule offer / core idle
//   plaintext [0:127]   : byte i = bits [8i +: 8], FIPS-197 column-major
//   keys                : expanded schedule, round key r = [128r +: 128]
//   out_valid/out_ready : ciphertext offer / downstream accept
//   ciphertext [0:127]  : result, same byte ordering as plaintext
//   busy                : block in flight (RUN or DONE)
// master = block producer/consumer, slave = cipher core.
interface aes128_cipher_core_if #(
  parameter int unsigned NR = aes_pkg::NR
);
  logic                    in_valid;
  logic                    in_ready;
  logic [0:127]            plaintext;
  logic [0:128*(NR+1)-1]   keys;
  logic                    out_valid;
  logic                    out_ready;
  logic [0:127]            ciphertext;
  logic                    busy;

  modport master (
    output in_valid, plaintext, keys, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, keys, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes128_cipher_core_round.sv
// One combinational AES encryption round.
//   state_in  : round input state
//   round_key : key added at the end of the round
//   last      : final round, MixColumns bypassed
//   state_out : SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey
module aes_round import aes_pkg::*; (
  input  logic [0:127] state_in,
  input  logic [0:127] round_key,
  input  logic         last,
  output logic [0:127] state_out
);
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte index = 4*column + row.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      sb[i] = sbox(state_in[i*8 +: 8]);
    end
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[c*4 + r] = sb[((c + r) % 4)*4 + r];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        mc[c*4 + r] = xtime(sr[c*4 + r]) ^ gf_mul3(sr[c*4 + (r + 1) % 4])
                    ^ sr[c*4 + (r + 2) % 4] ^ sr[c*4 + (r + 3) % 4];
      end
    end
    state_out = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      state_out[i*8 +: 8] = (last ? sr[i] : mc[i]) ^ round_key[i*8 +: 8];
    end
  end
endmodule

// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryption core: initial AddRoundKey on accept, then one
// round per clock, result held until taken downstream.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of aes128_cipher_core_if (in/out handshakes, busy)
// Keys are not latched; the round key is selected live by the round counter.
module aes128_cipher_core
  import aes_pkg::state_t, aes_pkg::IDLE, aes_pkg::RUN, aes_pkg::DONE;
#(
  parameter int unsigned NR = aes_pkg::NR
) (
  input logic                clk,
  input logic                rst,
  aes128_cipher_core_if.slave bus
);
  state_t       state_q, state_d;
  logic [3:0]   round_q;
  logic [0:127] st_q, ct_q;
  logic [0:127] round_key, round_out;
  logic         last, bad_round;

  assign last      = (round_q == 4'(NR));
  assign bad_round = (round_q > 4'(NR));

  always_comb begin
    round_key = '0;
    for (int unsigned r = 0; r <= NR; r++) begin
      if (round_q == r[3:0]) round_key = bus.keys[r*128 +: 128];
    end
  end

  aes_round u_round (
    .state_in  (st_q),
    .round_key (round_key),
    .last      (last),
    .state_out (round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (bad_round) state_d = IDLE;
               else if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // out_valid is decoded from DONE, which is entered on the final-round edge.
  always_comb begin
    bus.in_ready   = (state_q == IDLE);
    bus.out_valid  = (state_q == DONE);
    bus.busy       = (state_q == RUN) || (state_q == DONE);
    bus.ciphertext = ct_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_q <= '0;
      st_q    <= '0;
      ct_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            st_q    <= bus.plaintext ^ bus.keys[0:127];
            round_q <= 4'd1;
          end
        end
        RUN: begin
          if (bad_round) begin
            round_q <= '0;
          end else begin
            st_q <= round_out;
            if (last) begin
              ct_q    <= round_out;
              round_q <= '0;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
        end
        default: round_q <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_cipher_core.sv
// Directed bench for aes128_cipher_core: FIPS-197 vectors, latency,
// backpressure, busy-input rejection, async reset and back-to-back blocks.
// Key schedules and the reference cipher are computed here from an S-box
// derived algebraically (GF inverse + affine map).
module tb_aes128_cipher_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes128_cipher_core_if bus ();

  aes128_cipher_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  vectors = 0;
  int  miscompares = 0;
  int  accepts = 0;
  time last_acc = 0;
  logic [7:0] sb [256];

  always @(posedge clk) begin
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      accepts  <= accepts + 1;
      last_acc <= $time;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [0:1407] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[i*32 +: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [0:1407] ks);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ ks[i*8 +: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4*c + w] = t[4*((c + w) % 4) + w];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[r*128 + i*8 +: 8];
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  // Offers a block as soon as in_ready is seen; returns at the first
  // falling edge after the accept edge with in_valid dropped.
  task automatic accept(input logic [127:0] pt, input logic [0:1407] ks);
    int g;
    g = 0;
    while (bus.in_ready !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("accept_ready_seen", 128'(g < 40), 128'd1);
    bus.plaintext = pt;
    bus.keys      = ks;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  // n counts falling edges after the accept edge; out_valid is due at n = 11.
  task automatic wait_done(input int start, output int n);
    n = start;
    while (bus.out_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 128'(n < 60), 128'd1);
  endtask

  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [0:1407] ks_b, ks_c, ks_z, ks_r;
    logic [127:0]  pt_r, key_r, exp_r;
    int            n, acc_before;
    time           prev_acc;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.keys      = '0;
    prev_acc      = 0;
    build_sbox();
    ks_b = expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    ks_c = expand(128'h000102030405060708090a0b0c0d0e0f);
    ks_z = expand(128'h0);

    #2;
    check("rst_in_ready",   128'(bus.in_ready),  128'd1);
    check("rst_out_valid",  128'(bus.out_valid), 128'd0);
    check("rst_busy",       128'(bus.busy),      128'd0);
    check("rst_ciphertext", bus.ciphertext,      128'd0);
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 Appendix B with latency measurement
    bus.out_ready = 1'b1;
    accept(PT_B, ks_b);
    check("b_busy_run",     128'(bus.busy),     128'd1);
    check("b_in_ready_run", 128'(bus.in_ready), 128'd0);
    wait_done(1, n);
    check("b_latency", 128'(n), 128'd11);
    check("b_ct",      bus.ciphertext, CT_B);
    @(negedge clk);
    check("b_idle_in_ready",  128'(bus.in_ready),  128'd1);
    check("b_idle_out_valid", 128'(bus.out_valid), 128'd0);

    // Appendix C.1 under 20 cycles of backpressure, second block offered meanwhile
    bus.out_ready = 1'b0;
    acc_before = accepts;
    accept(PT_C, ks_c);
    wait_done(1, n);
    check("c1_latency", 128'(n), 128'd11);
    check("c1_ct",      bus.ciphertext, CT_C);
    bus.plaintext = '0;
    bus.keys      = ks_z;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(bus.out_valid), 128'd1);
      check("bp_ct_stable", bus.ciphertext,      CT_C);
      check("bp_in_ready",  128'(bus.in_ready),  128'd0);
    end
    check("bp_accepts_held", 128'(accepts - acc_before), 128'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready",  128'(bus.in_ready),  128'd1);
    check("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_second_accepted", 128'(accepts - acc_before), 128'd2);
    wait_done(1, n);
    check("bp_second_latency", 128'(n), 128'd11);
    check("bp_second_ct",      bus.ciphertext, CT_Z);

    // Input activity while busy must not disturb the block in flight
    acc_before = accepts;
    accept(PT_B, ks_b);
    for (int i = 0; i < 6; i++) begin
      bus.plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.in_valid  = ~bus.in_valid;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_done(7, n);
    check("busy_latency", 128'(n), 128'd11);
    check("busy_ct",      bus.ciphertext, CT_B);
    check("busy_accepts", 128'(accepts - acc_before), 128'd1);

    // Asynchronous reset during round 5, observed before any clock edge
    @(negedge clk);
    accept(PT_C, ks_c);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid",  128'(bus.out_valid), 128'd0);
    check("arst_in_ready",   128'(bus.in_ready),  128'd1);
    check("arst_busy",       128'(bus.busy),      128'd0);
    check("arst_ciphertext", bus.ciphertext,      128'd0);
    @(negedge clk);
    rst = 1'b0;
    accept(PT_C, ks_c);
    wait_done(1, n);
    check("arst_next_latency", 128'(n), 128'd11);
    check("arst_next_ct",      bus.ciphertext, CT_C);

    // Back-to-back random blocks, out_ready held high
    for (int k = 0; k < 8; k++) begin
      key_r = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt_r  = {$urandom(), $urandom(), $urandom(), $urandom()};
      ks_r  = expand(key_r);
      exp_r = encrypt(pt_r, ks_r);
      accept(pt_r, ks_r);
      if (k > 0) check("b2b_spacing", 128'(last_acc - prev_acc), 128'd120);
      prev_acc = last_acc;
      wait_done(1, n);
      check("b2b_ct", bus.ciphertext, exp_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
